// File: rtl/mem_stage_ctrl.sv
// Load/store sequencer between the MEM stage and a 16x16 data memory.
// Optional macro MEM_STAGE_BOUNDS_EN: out-of-range requests return resp_err.
module mem_stage_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int REQA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [REQA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_live;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_accept;
    logic              w_oob;

    assign w_accept = req_valid && req_ready;

`ifdef MEM_STAGE_BOUNDS_EN
    logic r_err;

    assign w_oob    = |req_addr[REQA_W-1:ADDR_W];
    assign resp_err = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && w_accept && w_oob) begin
            r_err <= 1'b1;
        end else if (r_state == RESP && resp_ready) begin
            r_err <= 1'b0;
        end
    end
`else
    // Upper address bits are deliberately dropped: the address wraps.
    logic w_unused_hi;

    assign w_unused_hi = |req_addr[REQA_W-1:ADDR_W];
    assign w_oob       = 1'b0;
    assign resp_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_oob) begin
                        w_next = RESP;
                    end else if (req_we) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            WR:   w_next = RESP;
            RD:   w_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Address/data only move on a real access so the bus stays quiet when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && w_accept && !w_oob) begin
            r_addr <= req_addr[ADDR_W-1:0];
            if (req_we) begin
                r_wdata <= req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept && w_oob) begin
                        r_rdata <= '0;
                    end
                end
                WR:      r_rdata <= '0;
                RD:      r_rdata <= mem_data_out;
                default: r_rdata <= r_rdata;
            endcase
        end
    end

    // Strobes are pure state decodes, so reset kills them asynchronously.
    assign req_ready    = r_live && (r_state == IDLE);
    assign resp_valid   = (r_state == RESP);
    assign resp_rdata   = r_rdata;
    assign mem_addr     = r_addr;
    assign mem_data_in  = r_wdata;
    assign mem_MemWrite = (r_state == WR);
    assign mem_MemRead  = (r_state == RD);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a behavioural 16x16 memory.
// Build with +define+MEM_STAGE_BOUNDS_EN to exercise the range check.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [15:0] mem_data_out;

    logic [15:0] mem [16];
    int          total;
    int          bad;

    mem_stage_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_MemWrite (mem_MemWrite),
        .mem_MemRead  (mem_MemRead),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_MemWrite) mem[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = mem_MemRead ? mem[mem_addr] : 16'h0;

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((mem_MemWrite & mem_MemRead) !== 1'b0) begin
                bad++;
                $display("FAIL excl got wr=%b rd=%b want not both",
                         mem_MemWrite, mem_MemRead);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        resp_ready = 1'b1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL st_ready got %b want 1", req_ready);
        end
        cyc();
        req_valid = 1'b0;
        total++;
        if ({mem_MemWrite, mem_MemRead, resp_valid} !== 3'b100) begin
            bad++;
            $display("FAIL st_strobe got %b%b%b want 100",
                     mem_MemWrite, mem_MemRead, resp_valid);
        end
        total++;
        if ({mem_addr, mem_data_in} !== {a[3:0], d}) begin
            bad++;
            $display("FAIL st_bus got %h/%h want %h/%h",
                     mem_addr, mem_data_in, a[3:0], d);
        end
        cyc();
        total++;
        if ({mem_MemWrite, resp_valid, resp_err, resp_rdata} !== {3'b010, 16'h0}) begin
            bad++;
            $display("FAIL st_resp got w=%b v=%b e=%b d=%h want 0 1 0 0000",
                     mem_MemWrite, resp_valid, resp_err, resp_rdata);
        end
        cyc();
        total++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL st_done got v=%b r=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic do_load(input logic [15:0] a, input logic [15:0] exp);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 16'h5555;
        resp_ready = 1'b1;
        cyc();
        req_valid = 1'b0;
        total++;
        if ({mem_MemWrite, mem_MemRead, resp_valid, mem_addr} !== {3'b010, a[3:0]}) begin
            bad++;
            $display("FAIL ld_strobe got %b%b%b a=%h want 010 a=%h",
                     mem_MemWrite, mem_MemRead, resp_valid, mem_addr, a[3:0]);
        end
        cyc();
        total++;
        if ({mem_MemRead, resp_valid, resp_err, resp_rdata} !== {3'b010, exp}) begin
            bad++;
            $display("FAIL ld_resp a=%h got r=%b v=%b e=%b d=%h want 0 1 0 %h",
                     a, mem_MemRead, resp_valid, resp_err, resp_rdata, exp);
        end
        cyc();
        total++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL ld_done got v=%b r=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; resp_ready = 1'b0;
        repeat (3) cyc();
        total++;
        if ({req_ready, resp_valid, resp_err, mem_MemWrite, mem_MemRead,
             mem_addr, mem_data_in, resp_rdata} !== 41'h0) begin
            bad++;
            $display("FAIL rst_state got rdy=%b v=%b w=%b r=%b a=%h want all 0",
                     req_ready, resp_valid, mem_MemWrite, mem_MemRead, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++; $display("FAIL rst_rdy_early got %b want 0", req_ready);
        end
        cyc();
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL rst_rdy got %b want 1", req_ready);
        end
        // Reset asserted in the middle of a read.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0005;
        cyc();
        req_valid = 1'b0;
        total++;
        if (mem_MemRead !== 1'b1) begin
            bad++; $display("FAIL rst_rd_pre got %b want 1", mem_MemRead);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_MemRead, mem_MemWrite, resp_valid, req_ready, mem_addr} !== 8'h0) begin
            bad++;
            $display("FAIL rst_mid_rd got r=%b v=%b rdy=%b a=%h want 0",
                     mem_MemRead, resp_valid, req_ready, mem_addr);
        end
        repeat (2) cyc();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        total++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            bad++;
            $display("FAIL rst_rel got rdy=%b v=%b want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) do_store(16'(i), 16'(i + 1));
        do_load(16'd5, 16'd6);
        do_load(16'd3, 16'd4);
        do_load(16'd11, 16'd12);
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd7; resp_ready = 1'b0;
        cyc();
        req_valid = 1'b0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd0; req_wdata = 16'hDEAD;
            total++;
            if ({resp_valid, req_ready, mem_MemWrite, resp_rdata} !== {3'b100, 16'd8}) begin
                bad++;
                $display("FAIL bp_hold k=%0d got v=%b rdy=%b w=%b d=%h want 1 0 0 0008",
                         k, resp_valid, req_ready, mem_MemWrite, resp_rdata);
            end
            cyc();
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        total++;
        if ({resp_valid, resp_rdata} !== {1'b1, 16'd8}) begin
            bad++;
            $display("FAIL bp_last got v=%b d=%h want 1 0008", resp_valid, resp_rdata);
        end
        cyc();
        total++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL bp_rel got v=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
        do_load(16'd0, 16'd1);
    endtask

    task automatic test_exclusive();
        do_store(16'd9, 16'hBEEF);
        do_load(16'd9, 16'hBEEF);
        do_store(16'd9, 16'h1234);
        do_load(16'd9, 16'h1234);
    endtask

    task automatic test_wrap();
`ifdef MEM_STAGE_BOUNDS_EN
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0012;
        req_wdata = 16'h00AA; resp_ready = 1'b1;
        cyc();
        req_valid = 1'b0;
        total++;
        if ({resp_valid, resp_err, mem_MemWrite, resp_rdata} !== {3'b110, 16'h0}) begin
            bad++;
            $display("FAIL oob_resp got v=%b e=%b w=%b d=%h want 1 1 0 0000",
                     resp_valid, resp_err, mem_MemWrite, resp_rdata);
        end
        cyc();
        total++;
        if ({resp_valid, resp_err, req_ready} !== 3'b001) begin
            bad++;
            $display("FAIL oob_clr got v=%b e=%b rdy=%b want 0 0 1",
                     resp_valid, resp_err, req_ready);
        end
        do_load(16'd2, 16'd3);
`else
        do_store(16'h0012, 16'h00AA);
        do_load(16'd2, 16'h00AA);
        do_load(16'h0013, 16'd4);
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        test_reset();
        test_fill();
        test_backpressure();
        test_exclusive();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
